// File: rtl/aw_fifo_sync.sv
// Single-clock FIFO for the AXI write-address channel, with a first-word-fall-through front entry.
// Optional same-cycle bypass of an empty FIFO when AW_FIFO_BYPASS_EN is defined.
module aw_fifo_sync #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4,
  parameter int SIZE_WIDTH = 3,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_WIDTH-1:0]        AWID,
  input  logic [ADDR_WIDTH-1:0]      AWADDR,
  input  logic [LEN_WIDTH-1:0]       AWLEN,
  input  logic [SIZE_WIDTH-1:0]      AWSIZE,
  input  logic [1:0]                 AWBURST,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic                       flush,
  output logic                       front_valid,
  input  logic                       front_ready,
  output logic [ID_WIDTH-1:0]        front_AWID,
  output logic [ADDR_WIDTH-1:0]      front_AWADDR,
  output logic [LEN_WIDTH-1:0]       front_AWLEN,
  output logic [SIZE_WIDTH-1:0]      front_AWSIZE,
  output logic [1:0]                 front_AWBURST,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int DW = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + 2;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] in_data, mem_data, front_data;
  logic          full, empty, push, pop, bypass;

  assign in_data  = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
  assign mem_data = mem[rd_ptr[PW-2:0]];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign count = wr_ptr - rd_ptr;
  assign almost_full = (count >= PW'(AF_THRESH));

  assign AWREADY = !full && !flush;

`ifdef AW_FIFO_BYPASS_EN
  assign bypass = empty && AWVALID && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign front_valid = !empty || bypass;
  assign front_data  = bypass ? in_data : mem_data;
  assign {front_AWID, front_AWADDR, front_AWLEN, front_AWSIZE, front_AWBURST} = front_data;

  // A bypassed entry taken in the same cycle never occupies a slot.
  assign push = AWVALID && AWREADY && !(bypass && front_ready);
  assign pop  = !empty && front_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-2:0]] <= in_data;
  end

endmodule

// File: tb/tb_aw_fifo_sync.sv
// Bench for aw_fifo_sync: directed sequences plus random traffic, checked against a queue model.
module tb_aw_fifo_sync;
  localparam int DEPTH = 8;
  localparam int AF_THRESH = 6;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0] AWLEN = '0;
  logic [2:0] AWSIZE = '0;
  logic [1:0] AWBURST = '0;
  logic AWVALID = 1'b0, AWREADY, flush = 1'b0, front_valid, front_ready = 1'b0;
  logic [3:0] front_AWID;
  logic [31:0] front_AWADDR;
  logic [3:0] front_AWLEN;
  logic [2:0] front_AWSIZE;
  logic [1:0] front_AWBURST;
  logic [CW-1:0] count;
  logic almost_full;

  aw_fifo_sync #(.ID_WIDTH(4), .ADDR_WIDTH(32), .LEN_WIDTH(4), .SIZE_WIDTH(3),
                 .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk(clk), .rst(rst), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY), .flush(flush),
    .front_valid(front_valid), .front_ready(front_ready), .front_AWID(front_AWID),
    .front_AWADDR(front_AWADDR), .front_AWLEN(front_AWLEN), .front_AWSIZE(front_AWSIZE),
    .front_AWBURST(front_AWBURST), .count(count), .almost_full(almost_full));

  always #5 clk = ~clk;

  ent_t q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input int i);
    ent_t e;
    e.id = 4'(i);
    e.addr = 32'h1000 + 32'(16 * i);
    e.len = 4'(i + 1);
    e.size = 3'(i);
    e.burst = 2'(i);
    return e;
  endfunction

  function automatic ent_t rnd();
    ent_t e;
    e.id = 4'($urandom);
    e.addr = $urandom;
    e.len = 4'($urandom);
    e.size = 3'($urandom);
    e.burst = 2'($urandom);
    return e;
  endfunction

  // One clock cycle: drive at negedge, check combinational outputs, then apply the model at posedge.
  task automatic step(input logic awv, input ent_t e, input logic fr, input logic fl);
    int sz;
    logic byp, exp_fv, exp_rdy, do_pop, do_push;
    ent_t exp_front;
    @(negedge clk);
    AWVALID = awv;
    {AWID, AWADDR, AWLEN, AWSIZE, AWBURST} = e;
    front_ready = fr;
    flush = fl;
    #1;
    sz = q.size();
    byp = 1'b0;
`ifdef AW_FIFO_BYPASS_EN
    byp = (sz == 0) && awv && !fl;
`endif
    exp_fv = (sz > 0) || byp;
    exp_rdy = (sz < DEPTH) && !fl;
    exp_front = byp ? e : ((sz > 0) ? q[0] : '0);
    check("awready", 64'(AWREADY), 64'(exp_rdy));
    check("front_valid", 64'(front_valid), 64'(exp_fv));
    check("count", 64'(count), 64'(sz));
    check("almost_full", 64'(almost_full), 64'(sz >= AF_THRESH));
    if (exp_fv)
      check("front_fields", 64'({front_AWID, front_AWADDR, front_AWLEN, front_AWSIZE, front_AWBURST}),
            64'(exp_front));
    do_pop = (sz > 0) && fr;
    do_push = awv && exp_rdy && !(byp && fr);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  endtask

  initial begin
    ent_t z;
    z = '0;
    #1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_front_valid", 64'(front_valid), 64'(0));
    check("rst_awready", 64'(AWREADY), 64'(1));
    check("rst_almost_full", 64'(almost_full), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Fill to full with no consumer, then one more cycle to see AWREADY low.
    for (int i = 0; i < 8; i++) step(1'b1, mk(i), 1'b0, 1'b0);
    step(1'b1, mk(9), 1'b0, 1'b0);
    // Drain all eight in order.
    for (int i = 0; i < 8; i++) step(1'b0, z, 1'b1, 1'b0);
    step(1'b0, z, 1'b1, 1'b0);

    // Streaming at one entry per cycle across two wraps.
    for (int i = 0; i < 20; i++) step(1'b1, mk(i + 3), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, z, 1'b1, 1'b0);

    // Flush with a simultaneous push and pop attempt.
    for (int i = 0; i < 3; i++) step(1'b1, mk(i + 5), 1'b0, 1'b0);
    step(1'b1, mk(12), 1'b1, 1'b1);
    step(1'b0, z, 1'b0, 1'b0);

    // Asynchronous reset between edges with five entries stored.
    for (int i = 0; i < 5; i++) step(1'b1, mk(i), 1'b0, 1'b0);
    AWVALID = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'(0));
    check("arst_front_valid", 64'(front_valid), 64'(0));
    check("arst_awready", 64'(AWREADY), 64'(1));
    check("arst_almost_full", 64'(almost_full), 64'(0));
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    // Empty FIFO, entry offered with consumer ready (bypass case when enabled).
    z.id = 4'hA;
    step(1'b1, z, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), rnd(), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 31) == 0));
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aw_fifo_sync.md
Name: aw_fifo_sync

Overview:
Single-clock, parametrised-depth FIFO for the AXI write-address channel in the XBar. It sits between a master-side AW port and the arbiter/decoder.
- Upstream side: AWVALID/AWREADY handshake.
- Downstream side: first-word-fall-through front entry with its own valid/ready handshake.
- Also provides an occupancy count, an almost-full flag and a synchronous flush.

Parameters:
ID_WIDTH, 4, AWID width
ADDR_WIDTH, 32, AWADDR width
LEN_WIDTH, 4, AWLEN width
SIZE_WIDTH, 3, AWSIZE width
DEPTH, 8, number of entries; power of 2, minimum 2
AF_THRESH, 6, almost_full asserts when count >= AF_THRESH; range 1..DEPTH

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
AWID  input  ID_WIDTH  write ID in
AWADDR  input  ADDR_WIDTH  write address in
AWLEN  input  LEN_WIDTH  burst length in
AWSIZE  input  SIZE_WIDTH  burst size in
AWBURST  input  2  burst type in
AWVALID  input  1  upstream entry valid
AWREADY  output  1  FIFO can accept an entry
flush  input  1  synchronous clear of all entries
front_valid  output  1  front entry valid
front_ready  input  1  consumer takes front entry
front_AWID  output  ID_WIDTH  front entry ID
front_AWADDR  output  ADDR_WIDTH  front entry address
front_AWLEN  output  LEN_WIDTH  front entry length
front_AWSIZE  output  SIZE_WIDTH  front entry size
front_AWBURST  output  2  front entry burst type
count  output  $clog2(DEPTH)+1  current occupancy
almost_full  output  1  count >= AF_THRESH

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Storage: DEPTH x (ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+SIZE_WIDTH+2) register array.
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Index = lower bits.
- full/empty:
  - full when the pointers differ only in the MSB.
  - empty when the pointers are equal.
  - count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Handshakes:
  - push = AWVALID & AWREADY; AWREADY = !full.
  - pop = front_valid & front_ready; front_valid = !empty.
  - All five front_* fields are driven combinationally from mem[rd_ptr] (FWFT).
  - A pushed entry is visible on front_* the cycle after the push edge (1-cycle latency).
- Simultaneous push and pop:
  - Not empty and not full: both pointers advance; count unchanged.
  - Full: AWREADY=0, so no push; the pop frees one slot and AWREADY=1 next cycle.
  - Empty: front_valid=0, so no pop; the push completes.
- Wrap-around: pointer index wraps DEPTH-1 -> 0 and the MSB toggles; no bubble at wrap.
- flush: on the edge with flush=1, wr_ptr=rd_ptr=0 and any push/pop that cycle is discarded. During that cycle AWREADY is forced to 0.
- Reset (async, any cycle including mid-burst of pushes):
  - Pointers = 0, count = 0, front_valid = 0, AWREADY = 1, almost_full = 0.
  - Memory contents are not reset; front_* are don't-care while front_valid = 0.
- almost_full: derived combinationally from count.
- Holding rules:
  - Upstream AWVALID must hold with stable fields until accepted. The FIFO does not check this.
  - front_* remain stable while front_valid=1 and front_ready=0.

Optional Feature:
Macro AW_FIFO_BYPASS_EN.
- Defined, with the FIFO empty and AWVALID=1:
  - front_valid=1 combinationally in the same cycle, and front_* = AW* inputs.
  - If front_ready=1 in that cycle, the entry is consumed without being written; pointers are unchanged.
  - If front_ready=0, the entry is written normally.
  - flush=1 suppresses the bypass.
- Not defined: front_valid depends only on !empty; minimum latency is 1 cycle.

Test Plan:
- Reset then push 8 entries (AWID 0..7, AWADDR 0x1000+16*i) with front_ready=0 -> AWREADY drops after the 8th; count=8; almost_full rises when count reaches 6.
- From full, set front_ready=1 for 8 cycles -> AWID 0..7 emerge in order, front_valid=0 after the last, count=0, AWREADY=1.
- Continuous push and pop at 1 entry/cycle for 20 entries -> output order matches input order across two wraps; count holds at 1 after the first cycle.
- Push 3, then assert flush with AWVALID=1 and front_ready=1 -> next cycle count=0, front_valid=0, nothing popped, and the flush-cycle push is dropped.
- Assert rst asynchronously between edges with count=5 -> outputs reset immediately: count=0, front_valid=0, AWREADY=1.
- With AW_FIFO_BYPASS_EN, empty FIFO, AWVALID=1, AWID=0xA, front_ready=1 -> front_valid=1 and front_AWID=0xA in the same cycle; count stays 0.
